vga_mode_sched: RTL and testbench

VGA_MODE_SCHED -- requirements
Module: vga_mode_sched

---
 rtl/vga_sched_pkg.sv | 16 +
 rtl/vga_fade_scaler.sv | 31 +++
 rtl/vga_mode_sched.sv | 121 ++++++++++++
 tb/tb_vga_mode_sched.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sched_pkg.sv
// Shared constants for the VGA mode-change scheduler.
// States, fade range and field widths used by every file of the block.
package vga_sched_pkg;

  localparam int MODE_W = 8;
  localparam int FADE_W = 4;
  localparam int PIX_W  = 24;

  localparam logic [FADE_W-1:0] FADE_MAX = 4'd8;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FADE_OUT = 2'd1;
  localparam logic [1:0] S_SWAP     = 2'd2;
  localparam logic [1:0] S_FADE_IN  = 2'd3;

endpackage

// File: rtl/vga_fade_scaler.sv
// Per-channel brightness scaler: out = (in * level) >> 3, one cycle latency.
// At level 8 the multiply and shift cancel, so pixels pass through unchanged.
module vga_fade_scaler
  import vga_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic [FADE_W-1:0] level,
  output logic [PIX_W-1:0] pix_out
);

  logic [11:0] prod [3];

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      prod[c] = {4'd0, pix_in[8*c +: 8]} * {8'd0, level};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_out <= '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        pix_out[8*c +: 8] <= 8'(prod[c] >> 3);
      end
    end
  end

endmodule

// File: rtl/vga_mode_sched.sv
// Tear-free display mode switcher with optional frame-paced fade.
// Define VGA_FADE_EN to fade out/in around the swap; otherwise swap only.
module vga_mode_sched
  import vga_sched_pkg::*;
#(
  parameter logic [MODE_W-1:0] RESET_MODE  = 8'h00,
  parameter int                STEP_FRAMES = 2
) (
  input  logic              vga_clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              req_valid,
  input  logic [MODE_W-1:0] req_mode,
  output logic              req_ready,
  input  logic [PIX_W-1:0]  pix_in,
  output logic [MODE_W-1:0] disp_mode,
  output logic [FADE_W-1:0] fade_level,
  output logic [PIX_W-1:0]  pix_out,
  output logic              busy,
  output logic              xfer_done
);

  logic [1:0]        state;
  logic [MODE_W-1:0] pending_mode;
  logic [FADE_W-1:0] frm_cnt;
  logic              accept;
  logic              step;

  assign req_ready = (state == S_IDLE);
  assign busy      = ~req_ready;
  assign accept    = req_valid & req_ready;
  assign step      = frame_tick &&
                     (frm_cnt == FADE_W'(STEP_FRAMES - 1));

`ifdef VGA_FADE_EN
  localparam logic [1:0] S_AFTER_REQ  = S_FADE_OUT;
  localparam logic [1:0] S_AFTER_SWAP = S_FADE_IN;

  logic [FADE_W-1:0] level;

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      level <= FADE_MAX;
    end else if (step) begin
      unique case (state)
        S_FADE_OUT: level <= level - 4'd1;
        S_FADE_IN:  level <= level + 4'd1;
        default:    level <= level;
      endcase
    end
  end

  assign fade_level = level;
`else
  localparam logic [1:0] S_AFTER_REQ  = S_SWAP;
  localparam logic [1:0] S_AFTER_SWAP = S_IDLE;

  assign fade_level = FADE_MAX;
`endif

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state        <= S_IDLE;
      disp_mode    <= RESET_MODE;
      pending_mode <= RESET_MODE;
      frm_cnt      <= '0;
      xfer_done    <= 1'b0;
    end else begin
      xfer_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // a tick on the accept cycle is deliberately not counted
          frm_cnt <= '0;
          if (accept) begin
            if (req_mode == disp_mode) begin
              xfer_done <= 1'b1;
            end else begin
              pending_mode <= req_mode;
              state        <= S_AFTER_REQ;
            end
          end
        end
        S_FADE_OUT: begin
          if (frame_tick) begin
            frm_cnt <= step ? '0 : frm_cnt + 4'd1;
            if (step && fade_level == 4'd1) begin
              state <= S_SWAP;
            end
          end
        end
        S_SWAP: begin
          frm_cnt <= '0;
          if (frame_tick) begin
            disp_mode <= pending_mode;
            state     <= S_AFTER_SWAP;
            xfer_done <= (S_AFTER_SWAP == S_IDLE);
          end
        end
        S_FADE_IN: begin
          if (frame_tick) begin
            frm_cnt <= step ? '0 : frm_cnt + 4'd1;
            if (step && fade_level == FADE_MAX - 4'd1) begin
              state     <= S_IDLE;
              xfer_done <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  vga_fade_scaler u_scaler (
    .clk     (vga_clk),
    .rst     (rst),
    .pix_in  (pix_in),
    .level   (fade_level),
    .pix_out (pix_out)
  );

endmodule

// File: tb/tb_vga_mode_sched.sv
// Randomized bench for vga_mode_sched against a tick-count reference model.
// Build with or without VGA_FADE_EN; the model follows the same macro.
module tb_vga_mode_sched;

  localparam logic [7:0] RM = 8'h00;
  localparam int S = 2;
`ifdef VGA_FADE_EN
  localparam int F  = 8 * S;
  localparam bit FE = 1'b1;
`else
  localparam int F  = 0;
  localparam bit FE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        req_valid = 1'b0;
  logic [7:0]  req_mode = 8'h00;
  logic        req_ready;
  logic [23:0] pix_in = 24'h0;
  logic [7:0]  disp_mode;
  logic [3:0]  fade_level;
  logic [23:0] pix_out;
  logic        busy;
  logic        xfer_done;

  logic        s_rst = 1'b0;
  logic [23:0] s_pix = 24'h0;
  logic [3:0]  s_lvl = 4'd8;
  logic [23:0] s_out;

  always #5 clk = ~clk;

  vga_mode_sched #(.RESET_MODE(RM), .STEP_FRAMES(S)) dut (
    .vga_clk    (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .req_valid  (req_valid),
    .req_mode   (req_mode),
    .req_ready  (req_ready),
    .pix_in     (pix_in),
    .disp_mode  (disp_mode),
    .fade_level (fade_level),
    .pix_out    (pix_out),
    .busy       (busy),
    .xfer_done  (xfer_done)
  );

  vga_fade_scaler u_scl (
    .clk     (clk),
    .rst     (s_rst),
    .pix_in  (s_pix),
    .level   (s_lvl),
    .pix_out (s_out)
  );

  int total = 0;
  int bad   = 0;
  int xcnt  = 0;
  int tph   = 0;

  // model: ticks counted since acceptance drive everything
  bit         m_busy = 1'b0;
  int         m_t    = 0;
  logic [7:0] m_disp = RM;
  logic [7:0] m_pend = RM;
  bit         m_xfer = 1'b0;
  logic [23:0] m_pix = 24'h0;
  int         m_lvl  = 8;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lvl_of(input bit b, input int t);
    if (!FE || !b) return 8;
    if (t <= F) return 8 - t / S;
    return (t - F - 1) / S;
  endfunction

  function automatic logic [23:0] scale(input logic [23:0] p, input int l);
    logic [23:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      r[8*c +: 8] = 8'((int'(p[8*c +: 8]) * l) / 8);
    end
    return r;
  endfunction

  task automatic model_edge(input bit r, input bit t, input bit v,
                            input logic [7:0] md, input logic [23:0] p);
    if (r) begin
      m_busy = 1'b0; m_t = 0; m_disp = RM; m_pend = RM;
      m_xfer = 1'b0; m_pix = 24'h0;
    end else begin
      m_pix  = scale(p, m_lvl);
      m_xfer = 1'b0;
      if (!m_busy) begin
        if (v) begin
          if (md == m_disp) m_xfer = 1'b1;
          else begin m_busy = 1'b1; m_t = 0; m_pend = md; end
        end
      end else if (t) begin
        m_t++;
        if (m_t == F + 1) m_disp = m_pend;
        if (m_t == 2 * F + 1) begin m_busy = 1'b0; m_xfer = 1'b1; end
      end
    end
    m_lvl = lvl_of(m_busy, m_t);
  endtask

  task automatic compare_all();
    check("disp",  32'(disp_mode),  32'(m_disp));
    check("level", 32'(fade_level), 32'(m_lvl));
    check("busy",  32'(busy),       32'(m_busy));
    check("ready", 32'(req_ready),  32'(!m_busy));
    check("xfer",  32'(xfer_done),  32'(m_xfer));
    check("pix",   32'(pix_out),    32'(m_pix));
  endtask

  task automatic cyc(input bit t);
    bit acc;
    frame_tick = t;
    pix_in = 24'($urandom);
    @(posedge clk);
    acc = !rst && req_valid && !m_busy;
    model_edge(rst, frame_tick, req_valid, req_mode, pix_in);
    #1;
    compare_all();
    xcnt += int'(xfer_done);
    if (acc) req_valid = 1'b0;
  endtask

  task automatic tcyc();
    tph++;
    cyc(tph % 3 == 0);
  endtask

  task automatic run_idle(input int maxc);
    int n;
    n = 0;
    while ((m_busy || req_valid) && n < maxc) begin
      tcyc();
      n++;
    end
    check("settle", 32'(busy), 32'd0);
  endtask

  logic [7:0] codes [4] = '{8'h00, 8'h03, 8'h05, 8'hA5};
  logic [23:0] sv_in  [4] = '{24'hFF8040, 24'hFF8040, 24'h123456, 24'hFFFFFF};
  logic [3:0]  sv_lvl [4] = '{4'd4, 4'd8, 4'd0, 4'd7};
  logic [23:0] sv_exp [4] = '{24'h7F4020, 24'hFF8040, 24'h000000, 24'hDFDFDF};

  initial begin
    rst = 1'b1;
    cyc(1'b0);
    cyc(1'b1);
    rst = 1'b0;
    cyc(1'b0);

    // no-op request for the current mode
    req_valid = 1'b1; req_mode = 8'h00; xcnt = 0;
    run_idle(10);
    tcyc();
    check("noop_xfer", 32'(xcnt), 32'd1);

    // full transition 00 -> 03
    req_valid = 1'b1; req_mode = 8'h03; xcnt = 0;
    run_idle(400);
    check("xfer_once", 32'(xcnt), 32'd1);

    // second request held while busy
    req_valid = 1'b1; req_mode = 8'h05;
    repeat (6) tcyc();
    req_valid = 1'b1; req_mode = 8'h00;
    run_idle(800);

    // reset while waiting in the swap phase
    req_valid = 1'b1; req_mode = 8'h03;
    for (int i = 0; i < 400; i++) begin
      if (m_busy && m_t == F) break;
      tcyc();
    end
    check("swap_reach", 32'(busy), 32'd1);
    rst = 1'b1; xcnt = 0;
    cyc(1'b0);
    rst = 1'b0;
    cyc(1'b0);
    cyc(1'b1);
    check("rst_noxfer", 32'(xcnt), 32'd0);

    // random phase
    for (int i = 0; i < 3000; i++) begin
      bit t;
      t = ($urandom % 3 == 0) && !frame_tick;
      if (!req_valid && $urandom % 6 == 0) begin
        req_valid = 1'b1;
        req_mode = codes[$urandom % 4];
      end
      rst = ($urandom % 400 == 0);
      cyc(t);
    end
    rst = 1'b0;

    // scaler arithmetic at chosen levels
    for (int i = 0; i < 4; i++) begin
      s_pix = sv_in[i];
      s_lvl = sv_lvl[i];
      @(posedge clk);
      #1;
      check("scaler", 32'(s_out), 32'(sv_exp[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
